// File: rtl/module_7_segments_scan.sv
// Multiplexed common-anode 7-segment scan driver with double-buffered digits,
// hex/BCD decode, leading-zero blanking, per-digit dp, PWM dimming, frame pulse.
// Latency: one clock from scan state to pins. No backpressure: loads are always accepted.
//
// Ports:
//   clk           system clock
//   rst_i         synchronous reset, active-low
//   bcd_i         digit nibbles, nibble k = digit k (k=0 rightmost)
//   dp_i          decimal point request per digit (1 = lit)
//   load_i        capture bcd_i/dp_i; becomes visible at the next frame boundary
//   hex_i         1: show 10..15 as A..F, 0: show them blank (live)
//   blank_lz_i    leading-zero blanking enable (live)
//   brillo_i      brightness, duty = (brillo_i+1)/2^BRIGHT_WIDTH (live)
//   anodo_o       anode enables, active-low
//   catodo_o      segments {g,f,e,d,c,b,a}, active-low
//   dp_o          decimal point segment, active-low
//   frame_o       one-cycle pulse after the last slot of each scan
module module_7_segments_scan #(
  parameter int NUM_DIGITS      = 4,
  parameter int DISPLAY_REFRESH = 27000,
  parameter int BRIGHT_WIDTH    = 4
) (
  input  logic                      clk,
  input  logic                      rst_i,
  input  logic [4*NUM_DIGITS-1:0]   bcd_i,
  input  logic [NUM_DIGITS-1:0]     dp_i,
  input  logic                      load_i,
  input  logic                      hex_i,
  input  logic                      blank_lz_i,
  input  logic [BRIGHT_WIDTH-1:0]   brillo_i,
  output logic [NUM_DIGITS-1:0]     anodo_o,
  output logic [6:0]                catodo_o,
  output logic                      dp_o,
  output logic                      frame_o
);

  localparam int CW = $clog2(DISPLAY_REFRESH);
  localparam int IW = $clog2(NUM_DIGITS);

  logic [CW-1:0]             cuenta_q, cuenta_d;
  logic [IW-1:0]             idx_q, idx_d;
  logic [BRIGHT_WIDTH-1:0]   pwm_q, pwm_d;
  logic [4*NUM_DIGITS-1:0]   pend_bcd_q, pend_bcd_d, act_bcd_q, act_bcd_d;
  logic [NUM_DIGITS-1:0]     pend_dp_q, pend_dp_d, act_dp_q, act_dp_d;
  logic [NUM_DIGITS-1:0]     anodo_q, anodo_d;
  logic [6:0]                catodo_q, catodo_d;
  logic                      dp_q, dp_d;
  logic                      frame_q, frame_d;

  logic                      slot_end, boundary, lit, blank, lz_run;
  logic [3:0]                nib;
  logic [NUM_DIGITS-1:0]     lz_mask;

  function automatic logic [6:0] seg7(input logic [3:0] v, input logic hex);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    if (!hex && v > 4'd9) s = 7'b1111111;
    return s;
  endfunction

  // Digit k is a leading zero when it and all higher digits are 0 with no dp.
  // Digit 0 is never marked so a value of zero still shows a single 0.
  always_comb begin
    lz_run  = 1'b1;
    lz_mask = '0;
    for (int k = NUM_DIGITS-1; k >= 1; k--) begin
      lz_run     = lz_run & (act_bcd_q[4*k +: 4] == 4'd0) & ~act_dp_q[k];
      lz_mask[k] = lz_run;
    end
  end

  always_comb begin
    slot_end = (cuenta_q == '0);
    boundary = slot_end && (idx_q == IW'(NUM_DIGITS-1));

    cuenta_d = slot_end ? CW'(DISPLAY_REFRESH-1) : cuenta_q - CW'(1);
    pwm_d    = slot_end ? '0 : pwm_q + BRIGHT_WIDTH'(1);
    idx_d    = idx_q;
    if (slot_end) idx_d = boundary ? '0 : idx_q + IW'(1);

    // A load also refreshes pending on the boundary itself, so an older
    // pending value can never resurface in a later frame.
    pend_bcd_d = load_i ? bcd_i : pend_bcd_q;
    pend_dp_d  = load_i ? dp_i  : pend_dp_q;
    act_bcd_d  = act_bcd_q;
    act_dp_d   = act_dp_q;
    if (boundary) begin
      act_bcd_d = load_i ? bcd_i : pend_bcd_q;
      act_dp_d  = load_i ? dp_i  : pend_dp_q;
    end

    nib   = act_bcd_q[{idx_q, 2'b00} +: 4];
    blank = blank_lz_i & lz_mask[idx_q];
    lit   = (pwm_q <= brillo_i);

    anodo_d  = '1;
    catodo_d = 7'b1111111;
    dp_d     = 1'b1;
    if (lit) begin
      anodo_d  = ~({{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx_q);
      catodo_d = blank ? 7'b1111111 : seg7(nib, hex_i);
      dp_d     = ~(act_dp_q[idx_q] & ~blank);
    end
    frame_d = boundary;
  end

  always_ff @(posedge clk) begin
    if (!rst_i) begin
      cuenta_q   <= CW'(DISPLAY_REFRESH-1);
      idx_q      <= '0;
      pwm_q      <= '0;
      pend_bcd_q <= '0;
      pend_dp_q  <= '0;
      act_bcd_q  <= '0;
      act_dp_q   <= '0;
      anodo_q    <= '1;
      catodo_q   <= 7'b1111111;
      dp_q       <= 1'b1;
      frame_q    <= 1'b0;
    end else begin
      cuenta_q   <= cuenta_d;
      idx_q      <= idx_d;
      pwm_q      <= pwm_d;
      pend_bcd_q <= pend_bcd_d;
      pend_dp_q  <= pend_dp_d;
      act_bcd_q  <= act_bcd_d;
      act_dp_q   <= act_dp_d;
      anodo_q    <= anodo_d;
      catodo_q   <= catodo_d;
      dp_q       <= dp_d;
      frame_q    <= frame_d;
    end
  end

  assign anodo_o  = anodo_q;
  assign catodo_o = catodo_q;
  assign dp_o     = dp_q;
  assign frame_o  = frame_q;

endmodule

// File: tb/tb_module_7_segments_scan.sv
module tb_module_7_segments_scan;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [15:0] bcd_i;
  logic [3:0]  dp_i;
  logic        load_i, hex_i, blank_lz_i;
  logic [1:0]  brillo_i;
  logic [3:0]  anodo_o;
  logic [6:0]  catodo_o;
  logic        dp_o, frame_o;

  module_7_segments_scan #(
    .NUM_DIGITS(4), .DISPLAY_REFRESH(20), .BRIGHT_WIDTH(2)
  ) dut (
    .clk(clk), .rst_i(rst_i), .bcd_i(bcd_i), .dp_i(dp_i), .load_i(load_i),
    .hex_i(hex_i), .blank_lz_i(blank_lz_i), .brillo_i(brillo_i),
    .anodo_o(anodo_o), .catodo_o(catodo_o), .dp_o(dp_o), .frame_o(frame_o)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct packed {
    logic [15:0]     bcd;
    logic [3:0]      dp;
    logic            hex;
    logic            blz;
    logic [3:0][6:0] cat;   // expected cathodes, digit 3 first
    logic [3:0]      dpo;   // expected dp_o per digit
  } vec_t;

  vec_t vecs [9];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // Returns after the edge that raises frame_o (bounded).
  task automatic wait_frame();
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!frame_o && n < 300);
    chk("frame_seen", {31'd0, frame_o}, 32'd1);
  endtask

  task automatic load(input logic [15:0] b, input logic [3:0] d);
    bcd_i  = b;
    dp_i   = d;
    load_i = 1'b1;
    tick();
    load_i = 1'b0;
  endtask

  initial begin
    int cnt, bad1, bad2;
    logic [3:0] an_exp;

    vecs[0] = '{16'h1234, 4'b0000, 1'b1, 1'b0,
                {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}, 4'b1111};
    vecs[1] = '{16'h00AF, 4'b0000, 1'b1, 1'b0,
                {7'b1000000, 7'b1000000, 7'b0001000, 7'b0001110}, 4'b1111};
    vecs[2] = '{16'h00AF, 4'b0000, 1'b0, 1'b0,
                {7'b1000000, 7'b1000000, 7'b1111111, 7'b1111111}, 4'b1111};
    vecs[3] = '{16'h00AF, 4'b0000, 1'b1, 1'b1,
                {7'b1111111, 7'b1111111, 7'b0001000, 7'b0001110}, 4'b1111};
    vecs[4] = '{16'h0000, 4'b0000, 1'b1, 1'b1,
                {7'b1111111, 7'b1111111, 7'b1111111, 7'b1000000}, 4'b1111};
    vecs[5] = '{16'h0000, 4'b0100, 1'b1, 1'b1,
                {7'b1111111, 7'b1000000, 7'b1000000, 7'b1000000}, 4'b1011};
    vecs[6] = '{16'h8765, 4'b1010, 1'b1, 1'b1,
                {7'b0000000, 7'b1111000, 7'b0000010, 7'b0010010}, 4'b0101};
    vecs[7] = '{16'hBCDE, 4'b0000, 1'b1, 1'b0,
                {7'b0000011, 7'b1000110, 7'b0100001, 7'b0000110}, 4'b1111};
    vecs[8] = '{16'h0900, 4'b0000, 1'b0, 1'b1,
                {7'b1111111, 7'b0010000, 7'b1000000, 7'b1000000}, 4'b1111};

    rst_i = 1'b0; bcd_i = '0; dp_i = '0; load_i = 1'b0;
    hex_i = 1'b1; blank_lz_i = 1'b0; brillo_i = 2'd3;

    // Reset state and release
    repeat (3) tick();
    chk("rst_anodo",  {28'd0, anodo_o},  32'hF);
    chk("rst_catodo", {25'd0, catodo_o}, 32'h7F);
    chk("rst_dp",     {31'd0, dp_o},     32'd1);
    chk("rst_frame",  {31'd0, frame_o},  32'd0);
    rst_i = 1'b1;
    tick(); tick();
    chk("rel_digit0_anodo",  {28'd0, anodo_o},  32'b1110);
    chk("rel_digit0_catodo", {25'd0, catodo_o}, 32'b1000000);
    repeat (20) tick();
    chk("rel_digit1_anodo",  {28'd0, anodo_o},  32'b1101);

    // Frame pulse is one cycle wide and repeats every 80 clocks
    wait_frame();
    tick();
    chk("frame_width", {31'd0, frame_o}, 32'd0);
    cnt = 1;
    while (!frame_o && cnt < 200) begin
      tick();
      cnt++;
    end
    chk("frame_period", cnt, 32'd80);

    // Table-driven display vectors, sampled at each slot start
    foreach (vecs[v]) begin
      hex_i      = vecs[v].hex;
      blank_lz_i = vecs[v].blz;
      load(vecs[v].bcd, vecs[v].dp);
      wait_frame();
      tick();
      for (int k = 0; k < 4; k++) begin
        an_exp = 4'b1111 ^ (4'b0001 << k);
        chk($sformatf("v%0d_d%0d_anodo", v, k),  {28'd0, anodo_o},  {28'd0, an_exp});
        chk($sformatf("v%0d_d%0d_catodo", v, k), {25'd0, catodo_o}, {25'd0, vecs[v].cat[k]});
        chk($sformatf("v%0d_d%0d_dp", v, k),     {31'd0, dp_o},     {31'd0, vecs[v].dpo[k]});
        if (k < 3) repeat (20) tick();
      end
    end

    // Mid-scan reset discards pending data
    hex_i = 1'b1; blank_lz_i = 1'b0;
    wait_frame();
    repeat (10) tick();
    load(16'h5555, 4'b0000);
    repeat (5) tick();
    rst_i = 1'b0;
    tick(); tick();
    chk("midrst_anodo",  {28'd0, anodo_o},  32'hF);
    chk("midrst_catodo", {25'd0, catodo_o}, 32'h7F);
    chk("midrst_dp",     {31'd0, dp_o},     32'd1);
    chk("midrst_frame",  {31'd0, frame_o},  32'd0);
    rst_i = 1'b1;
    wait_frame();
    tick();
    chk("midrst_pending_dropped", {25'd0, catodo_o}, 32'b1000000);

    // PWM duty
    brillo_i = 2'd1;
    wait_frame();
    tick();
    for (int m = 0; m < 8; m++) begin
      chk($sformatf("pwm1_m%0d", m), {28'd0, anodo_o}, (m % 4 < 2) ? 32'b1110 : 32'b1111);
      tick();
    end
    brillo_i = 2'd0;
    wait_frame();
    tick();
    for (int m = 0; m < 8; m++) begin
      chk($sformatf("pwm0_m%0d", m), {28'd0, anodo_o}, (m % 4 == 0) ? 32'b1110 : 32'b1111);
      if (m == 2) chk("pwm0_off_catodo", {25'd0, catodo_o}, 32'h7F);
      tick();
    end

    // Tear-free update: 1111 loaded mid-frame is superseded by 2222 on the boundary
    brillo_i = 2'd3;
    load(16'h5678, 4'b0000);
    wait_frame();
    bad1 = 0;
    repeat (10) begin
      tick();
      if (catodo_o == 7'b1111001) bad1++;
    end
    load(16'h1111, 4'b0000);
    if (catodo_o == 7'b1111001) bad1++;
    repeat (68) begin
      tick();
      if (catodo_o == 7'b1111001) bad1++;
    end
    load(16'h2222, 4'b0000);
    bcd_i = 16'h0000;
    chk("tear_boundary_frame", {31'd0, frame_o}, 32'd1);
    if (catodo_o == 7'b1111001) bad1++;
    bad2 = 0;
    repeat (160) begin
      tick();
      if (catodo_o == 7'b1111001) bad1++;
      if (catodo_o != 7'b0100100) bad2++;
    end
    chk("tear_never_1111", bad1, 32'd0);
    chk("tear_all_2222",   bad2, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
